unidade_controle_jogo: RTL and testbench

- Moore FSM that sequences the memory-game datapath: counters, ROM, registers, timeout counter and display timer.
- Each round has two phases: it shows the stored sequence, then collects and checks the player's moves.
- It reports the result as win, loss or timeout.
- It sits beside the data path in the top level and drives all zera/registra/conta strobes; it consumes the datapath's status flags.

---
 rtl/unidade_controle_jogo_if.sv | 53 +++++
 rtl/unidade_controle_jogo.sv | 158 +++++++++++++++
 tb/tb_unidade_controle_jogo.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/unidade_controle_jogo_if.sv
// rtl/unidade_controle_jogo_if.sv - control/status bundle between game FSM and datapath
//
// Groups every non-clock/reset signal of the memory-game control unit.
//   master : the control unit (consumes requests and status, drives strobes)
//   slave  : the datapath / environment side (mirror directions)
// Signals:
//   iniciar, jogada_feita                         player requests
//   chavesIgualMemoria, enderecoIgualSequencia,
//   fimL, fimTMR, timeout                         datapath status flags
//   zeraE/L/R/M/TMR, contaE/L/TMR, registraR/M    datapath strobes
//   pronto, ganhou, perdeu, db_timeout            game result
//   db_estado                                     current state code

interface unidade_controle_jogo_if #(
    parameter int ESTADO_W = 5
) ();
    logic                iniciar;
    logic                jogada_feita;
    logic                chavesIgualMemoria;
    logic                enderecoIgualSequencia;
    logic                fimL;
    logic                fimTMR;
    logic                timeout;
    logic                zeraE;
    logic                zeraL;
    logic                zeraR;
    logic                zeraM;
    logic                zeraTMR;
    logic                contaE;
    logic                contaL;
    logic                contaTMR;
    logic                registraR;
    logic                registraM;
    logic                pronto;
    logic                ganhou;
    logic                perdeu;
    logic                db_timeout;
    logic [ESTADO_W-1:0] db_estado;

    modport master (
        input  iniciar, jogada_feita, chavesIgualMemoria, enderecoIgualSequencia,
               fimL, fimTMR, timeout,
        output zeraE, zeraL, zeraR, zeraM, zeraTMR, contaE, contaL, contaTMR,
               registraR, registraM, pronto, ganhou, perdeu, db_timeout, db_estado
    );

    modport slave (
        output iniciar, jogada_feita, chavesIgualMemoria, enderecoIgualSequencia,
               fimL, fimTMR, timeout,
        input  zeraE, zeraL, zeraR, zeraM, zeraTMR, contaE, contaL, contaTMR,
               registraR, registraM, pronto, ganhou, perdeu, db_timeout, db_estado
    );
endinterface

// File: rtl/unidade_controle_jogo.sv
// rtl/unidade_controle_jogo.sv - Moore control FSM for the memory game
//
// Sequences each round: shows the stored sequence item by item (display
// timer paced), then collects and compares the player's moves, ending in
// win, wrong-move loss or timeout loss.
// Ports:
//   clock  system clock
//   reset  synchronous, active-high; returns to inicial with all outputs low
//   ctl    unidade_controle_jogo_if.master (requests, status flags, strobes,
//          result flags, db_estado)

module unidade_controle_jogo #(
    parameter int ESTADO_W = 5
) (
    input  logic                          clock,
    input  logic                          reset,
    unidade_controle_jogo_if.master       ctl
);

    typedef enum logic [4:0] {
        INICIAL        = 5'h00,
        PREPARACAO     = 5'h01,
        INICIO_RODADA  = 5'h02,
        MOSTRA         = 5'h03,
        MOSTRA_FIM     = 5'h04,
        MOSTRA_PROX    = 5'h05,
        ESPERA_JOGADA  = 5'h06,
        REGISTRA       = 5'h07,
        COMPARACAO     = 5'h08,
        PROXIMO        = 5'h09,
        PROXIMA_RODADA = 5'h0A,
        FIM_ACERTOU    = 5'h0C,
        FIM_ERROU      = 5'h0D,
        FIM_TIMEOUT    = 5'h0E,
        FIM_MOSTRA     = 5'h0F
    } estado_t;

    typedef struct packed {
        logic zera_e;
        logic zera_l;
        logic zera_r;
        logic zera_m;
        logic zera_tmr;
        logic conta_e;
        logic conta_l;
        logic conta_tmr;
        logic registra_r;
        logic registra_m;
        logic pronto;
        logic ganhou;
        logic perdeu;
        logic db_timeout;
    } saidas_t;

    estado_t estado_q, estado_d;
    saidas_t saidas_q, saidas_d;

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            INICIAL:        if (ctl.iniciar) estado_d = PREPARACAO;
            PREPARACAO:     estado_d = INICIO_RODADA;
            INICIO_RODADA:  estado_d = MOSTRA;
            MOSTRA:         if (ctl.fimTMR) estado_d = MOSTRA_FIM;
            MOSTRA_FIM:     estado_d = ctl.enderecoIgualSequencia ? FIM_MOSTRA : MOSTRA_PROX;
            MOSTRA_PROX:    estado_d = MOSTRA;
            FIM_MOSTRA:     estado_d = ESPERA_JOGADA;
            // A move arriving in the same cycle as the timeout is still accepted.
            ESPERA_JOGADA: begin
                if (ctl.jogada_feita) estado_d = REGISTRA;
                else if (ctl.timeout) estado_d = FIM_TIMEOUT;
            end
            REGISTRA:       estado_d = COMPARACAO;
            COMPARACAO: begin
                if (!ctl.chavesIgualMemoria)          estado_d = FIM_ERROU;
                else if (!ctl.enderecoIgualSequencia) estado_d = PROXIMO;
                else if (ctl.fimL)                    estado_d = FIM_ACERTOU;
                else                                  estado_d = PROXIMA_RODADA;
            end
            PROXIMO:        estado_d = ESPERA_JOGADA;
            PROXIMA_RODADA: estado_d = INICIO_RODADA;
            FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT:
                            if (ctl.iniciar) estado_d = PREPARACAO;
            default:        estado_d = INICIAL;
        endcase

        // Outputs are decoded from the next state and registered with it, so
        // they are a pure function of the current state yet glitch-free.
        saidas_d = '0;
        case (estado_d)
            PREPARACAO: begin
                saidas_d.zera_e   = 1'b1;
                saidas_d.zera_l   = 1'b1;
                saidas_d.zera_r   = 1'b1;
                saidas_d.zera_m   = 1'b1;
                saidas_d.zera_tmr = 1'b1;
            end
            INICIO_RODADA: begin
                saidas_d.zera_e   = 1'b1;
                saidas_d.zera_tmr = 1'b1;
            end
            MOSTRA: begin
                saidas_d.registra_m = 1'b1;
                saidas_d.conta_tmr  = 1'b1;
            end
            MOSTRA_FIM:     saidas_d.zera_tmr = 1'b1;
            MOSTRA_PROX:    saidas_d.conta_e  = 1'b1;
            FIM_MOSTRA: begin
                saidas_d.zera_e = 1'b1;
                saidas_d.zera_r = 1'b1;
            end
            REGISTRA:       saidas_d.registra_r = 1'b1;
            PROXIMO:        saidas_d.conta_e    = 1'b1;
            PROXIMA_RODADA: saidas_d.conta_l    = 1'b1;
            FIM_ACERTOU: begin
                saidas_d.pronto = 1'b1;
                saidas_d.ganhou = 1'b1;
            end
            FIM_ERROU: begin
                saidas_d.pronto = 1'b1;
                saidas_d.perdeu = 1'b1;
            end
            FIM_TIMEOUT: begin
                saidas_d.pronto     = 1'b1;
                saidas_d.perdeu     = 1'b1;
                saidas_d.db_timeout = 1'b1;
            end
            default: saidas_d = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= INICIAL;
            saidas_q <= '0;
        end else begin
            estado_q <= estado_d;
            saidas_q <= saidas_d;
        end
    end

    assign ctl.zeraE      = saidas_q.zera_e;
    assign ctl.zeraL      = saidas_q.zera_l;
    assign ctl.zeraR      = saidas_q.zera_r;
    assign ctl.zeraM      = saidas_q.zera_m;
    assign ctl.zeraTMR    = saidas_q.zera_tmr;
    assign ctl.contaE     = saidas_q.conta_e;
    assign ctl.contaL     = saidas_q.conta_l;
    assign ctl.contaTMR   = saidas_q.conta_tmr;
    assign ctl.registraR  = saidas_q.registra_r;
    assign ctl.registraM  = saidas_q.registra_m;
    assign ctl.pronto     = saidas_q.pronto;
    assign ctl.ganhou     = saidas_q.ganhou;
    assign ctl.perdeu     = saidas_q.perdeu;
    assign ctl.db_timeout = saidas_q.db_timeout;
    assign ctl.db_estado  = ESTADO_W'(estado_q);

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// tb/tb_unidade_controle_jogo.sv - self-checking bench for unidade_controle_jogo

module tb_unidade_controle_jogo;

    localparam int ESTADO_W = 5;
    localparam int TMR_LEN  = 5;

    localparam int O_ZE = 13, O_ZL = 12, O_ZR = 11, O_ZM = 10, O_ZT = 9, O_CE = 8, O_CL = 7;
    localparam int O_CT = 6, O_RR = 5, O_RM = 4, O_PR = 3, O_GA = 2, O_PE = 1, O_DT = 0;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    unidade_controle_jogo_if #(.ESTADO_W(ESTADO_W)) bus ();

    unidade_controle_jogo #(.ESTADO_W(ESTADO_W)) dut (
        .clock (clock),
        .reset (reset),
        .ctl   (bus)
    );

    int assertions = 0;
    int failures   = 0;

    // Environment datapath: address/round/timer counters, move register, ROM.
    logic [3:0] rom [16];
    logic [3:0] end_e = '0;
    logic [3:0] rod_l = '0;
    logic [3:0] tmr   = '0;
    logic [3:0] reg_r = '0;
    logic [3:0] jogada_val;
    int         last_round;

    always @(posedge clock) begin
        if (bus.zeraE) end_e <= '0;
        else if (bus.contaE) end_e <= end_e + 4'd1;
        if (bus.zeraL) rod_l <= '0;
        else if (bus.contaL) rod_l <= rod_l + 4'd1;
        if (bus.zeraTMR) tmr <= '0;
        else if (bus.contaTMR) tmr <= tmr + 4'd1;
        if (bus.zeraR) reg_r <= '0;
        else if (bus.registraR) reg_r <= jogada_val;
    end

    assign bus.enderecoIgualSequencia = (end_e == rod_l);
    assign bus.fimL                   = (int'(rod_l) == last_round);
    assign bus.fimTMR                 = (int'(tmr) == TMR_LEN - 1);
    assign bus.chavesIgualMemoria     = (reg_r == rom[end_e]);

    wire [13:0] outs = {bus.zeraE, bus.zeraL, bus.zeraR, bus.zeraM, bus.zeraTMR,
                        bus.contaE, bus.contaL, bus.contaTMR, bus.registraR, bus.registraM,
                        bus.pronto, bus.ganhou, bus.perdeu, bus.db_timeout};

    int cnt_reg_m = 0;
    int cnt_reg_r = 0;
    always @(negedge clock) begin
        if (bus.registraM) cnt_reg_m++;
        if (bus.registraR) cnt_reg_r++;
    end

    // Output table of each state as listed in the behaviour description.
    function automatic logic [13:0] spec_outs(input logic [4:0] st);
        logic [13:0] r;
        r = '0;
        case (st)
            5'h01: begin r[O_ZE] = 1; r[O_ZL] = 1; r[O_ZR] = 1; r[O_ZM] = 1; r[O_ZT] = 1; end
            5'h02: begin r[O_ZE] = 1; r[O_ZT] = 1; end
            5'h03: begin r[O_RM] = 1; r[O_CT] = 1; end
            5'h04: r[O_ZT] = 1;
            5'h05: r[O_CE] = 1;
            5'h0F: begin r[O_ZE] = 1; r[O_ZR] = 1; end
            5'h07: r[O_RR] = 1;
            5'h09: r[O_CE] = 1;
            5'h0A: r[O_CL] = 1;
            5'h0C: begin r[O_PR] = 1; r[O_GA] = 1; end
            5'h0D: begin r[O_PR] = 1; r[O_PE] = 1; end
            5'h0E: begin r[O_PR] = 1; r[O_PE] = 1; r[O_DT] = 1; end
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic wait_state(input logic [4:0] code, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.db_estado === code) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic press(input bit wrong, input bit with_timeout);
        jogada_val       = rom[end_e] ^ (wrong ? 4'h1 : 4'h0);
        bus.jogada_feita = 1'b1;
        bus.timeout      = with_timeout;
        tick();
        bus.jogada_feita = 1'b0;
        bus.timeout      = 1'b0;
    endtask

    task automatic start_game();
        bus.iniciar = 1'b1;
        tick();
        bus.iniciar = 1'b0;
    endtask

    task automatic fill_rom();
        for (int i = 0; i < 16; i++) rom[i] = 4'($urandom_range(0, 15));
    endtask

    task automatic test_reset();
        logic [4:0] seq [$];
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            assertions++;
            if (bus.db_estado !== 5'h00 || outs !== 14'h0) begin
                failures++;
                $display("FAIL reset_idle[%0d]: state=%h outs=%b, required state=00 outs=0", i, bus.db_estado, outs);
            end
            tick();
        end
        seq.delete();
    endtask

    task automatic test_round0_show();
        logic [4:0] seq [$];
        last_round = 3;
        fill_rom();
        start_game();
        seq = '{5'h01, 5'h02, 5'h03, 5'h03, 5'h03, 5'h03, 5'h03, 5'h04, 5'h0F, 5'h06};
        foreach (seq[i]) begin
            if (i > 0) tick();
            assertions++;
            if (bus.db_estado !== seq[i] || outs !== spec_outs(seq[i])) begin
                failures++;
                $display("FAIL round0_show[%0d]: state=%h outs=%b, required state=%h outs=%b",
                         i, bus.db_estado, outs, seq[i], spec_outs(seq[i]));
            end
        end
    endtask

    task automatic test_round1_play();
        logic [4:0] seq [$];
        press(1'b0, 1'b0);
        seq = '{5'h07, 5'h08, 5'h0A, 5'h02,
                5'h03, 5'h03, 5'h03, 5'h03, 5'h03, 5'h04, 5'h05,
                5'h03, 5'h03, 5'h03, 5'h03, 5'h03, 5'h04, 5'h0F, 5'h06};
        foreach (seq[i]) begin
            if (i > 0) tick();
            assertions++;
            if (bus.db_estado !== seq[i] || outs !== spec_outs(seq[i])) begin
                failures++;
                $display("FAIL round1_show[%0d]: state=%h outs=%b, required state=%h outs=%b",
                         i, bus.db_estado, outs, seq[i], spec_outs(seq[i]));
            end
        end
        for (int m = 0; m < 2; m++) begin
            press(1'b0, 1'b0);
            if (m == 0) seq = '{5'h07, 5'h08, 5'h09, 5'h06};
            else        seq = '{5'h07, 5'h08, 5'h0A, 5'h02};
            foreach (seq[i]) begin
                if (i > 0) tick();
                assertions++;
                if (bus.db_estado !== seq[i] || outs !== spec_outs(seq[i])) begin
                    failures++;
                    $display("FAIL round1_move%0d[%0d]: state=%h outs=%b, required state=%h outs=%b",
                             m, i, bus.db_estado, outs, seq[i], spec_outs(seq[i]));
                end
            end
        end
    endtask

    task automatic test_reset_mid_show();
        bit ok;
        wait_state(5'h03, 50, ok);
        assertions++;
        if (!ok) begin
            failures++;
            $display("FAIL reset_mid_reach: state=%h, required state=03", bus.db_estado);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            assertions++;
            if (bus.db_estado !== 5'h00 || outs !== 14'h0) begin
                failures++;
                $display("FAIL reset_mid[%0d]: state=%h outs=%b, required state=00 outs=0", i, bus.db_estado, outs);
            end
            tick();
        end
    endtask

    task automatic test_win();
        logic [4:0] seq [$];
        bit ok;
        last_round = 0;
        fill_rom();
        start_game();
        wait_state(5'h06, 100, ok);
        assertions++;
        if (!ok) begin
            failures++;
            $display("FAIL win_reach_wait: state=%h, required state=06", bus.db_estado);
        end
        press(1'b0, 1'b0);
        seq = '{5'h07, 5'h08, 5'h0C, 5'h0C, 5'h0C, 5'h0C};
        foreach (seq[i]) begin
            if (i > 0) tick();
            assertions++;
            if (bus.db_estado !== seq[i] || outs !== spec_outs(seq[i])) begin
                failures++;
                $display("FAIL win[%0d]: state=%h outs=%b, required state=%h outs=%b",
                         i, bus.db_estado, outs, seq[i], spec_outs(seq[i]));
            end
        end
        start_game();
        assertions++;
        if (bus.db_estado !== 5'h01 || outs !== spec_outs(5'h01)) begin
            failures++;
            $display("FAIL win_restart: state=%h outs=%b, required state=01 outs=%b",
                     bus.db_estado, outs, spec_outs(5'h01));
        end
    endtask

    task automatic test_wrong_move();
        logic [4:0] seq [$];
        bit ok;
        last_round = 2;
        wait_state(5'h06, 100, ok);
        assertions++;
        if (!ok) begin
            failures++;
            $display("FAIL wrong_reach_wait: state=%h, required state=06", bus.db_estado);
        end
        press(1'b1, 1'b0);
        seq = '{5'h07, 5'h08, 5'h0D, 5'h0D};
        foreach (seq[i]) begin
            if (i > 0) tick();
            assertions++;
            if (bus.db_estado !== seq[i] || outs !== spec_outs(seq[i])) begin
                failures++;
                $display("FAIL wrong_move[%0d]: state=%h outs=%b, required state=%h outs=%b",
                         i, bus.db_estado, outs, seq[i], spec_outs(seq[i]));
            end
        end
    endtask

    task automatic test_timeout();
        logic [4:0] seq [$];
        bit ok;
        start_game();
        wait_state(5'h06, 100, ok);
        assertions++;
        if (!ok) begin
            failures++;
            $display("FAIL timeout_reach_wait: state=%h, required state=06", bus.db_estado);
        end
        bus.timeout = 1'b1;
        tick();
        bus.timeout = 1'b0;
        seq = '{5'h0E, 5'h0E};
        foreach (seq[i]) begin
            if (i > 0) tick();
            assertions++;
            if (bus.db_estado !== seq[i] || outs !== spec_outs(seq[i])) begin
                failures++;
                $display("FAIL timeout_alone[%0d]: state=%h outs=%b, required state=%h outs=%b",
                         i, bus.db_estado, outs, seq[i], spec_outs(seq[i]));
            end
        end
    endtask

    task automatic test_timeout_and_move();
        logic [4:0] seq [$];
        bit ok;
        start_game();
        wait_state(5'h06, 100, ok);
        assertions++;
        if (!ok) begin
            failures++;
            $display("FAIL both_reach_wait: state=%h, required state=06", bus.db_estado);
        end
        press(1'b0, 1'b1);
        seq = '{5'h07, 5'h08, 5'h0A, 5'h02};
        foreach (seq[i]) begin
            if (i > 0) tick();
            assertions++;
            if (bus.db_estado !== seq[i] || outs !== spec_outs(seq[i])) begin
                failures++;
                $display("FAIL timeout_and_move[%0d]: state=%h outs=%b, required state=%h outs=%b",
                         i, bus.db_estado, outs, seq[i], spec_outs(seq[i]));
            end
        end
    endtask

    // Whole games with random length, contents and failure point; the model
    // predicts the ending and how many items were shown and moves registered.
    task automatic test_random_games();
        bit ok, done;
        int kind, fr, fk, base_m, base_r, exp_m, exp_r, rounds_shown;
        logic [4:0] exp_st;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int g = 0; g < 20; g++) begin
            last_round = $urandom_range(0, 4);
            fill_rom();
            kind = $urandom_range(0, 2);
            fr   = $urandom_range(0, last_round);
            fk   = $urandom_range(0, fr);
            if (kind == 0) begin
                exp_st       = 5'h0C;
                rounds_shown = last_round + 1;
                exp_r        = (last_round + 1) * (last_round + 2) / 2;
            end else begin
                exp_st       = (kind == 1) ? 5'h0D : 5'h0E;
                rounds_shown = fr + 1;
                exp_r        = fr * (fr + 1) / 2 + fk + ((kind == 1) ? 1 : 0);
            end
            exp_m  = TMR_LEN * rounds_shown * (rounds_shown + 1) / 2;
            base_m = cnt_reg_m;
            base_r = cnt_reg_r;
            start_game();
            done = 1'b0;
            for (int n = 0; n <= last_round; n++) begin
                if (done) break;
                for (int k = 0; k <= n; k++) begin
                    wait_state(5'h06, 300, ok);
                    if (!ok) begin
                        done = 1'b1;
                        break;
                    end
                    repeat ($urandom_range(0, 2)) tick();
                    if (kind == 2 && n == fr && k == fk) begin
                        bus.timeout = 1'b1;
                        tick();
                        bus.timeout = 1'b0;
                        done = 1'b1;
                        break;
                    end else if (kind == 1 && n == fr && k == fk) begin
                        press(1'b1, 1'($urandom_range(0, 1)));
                        done = 1'b1;
                        break;
                    end else begin
                        press(1'b0, 1'($urandom_range(0, 1)));
                    end
                end
            end
            wait_state(exp_st, 300, ok);
            assertions++;
            if (!ok || outs !== spec_outs(exp_st)) begin
                failures++;
                $display("FAIL game%0d_result: state=%h outs=%b, required state=%h outs=%b",
                         g, bus.db_estado, outs, exp_st, spec_outs(exp_st));
            end
            assertions++;
            if (cnt_reg_m - base_m !== exp_m) begin
                failures++;
                $display("FAIL game%0d_show_cycles: got %0d, required %0d", g, cnt_reg_m - base_m, exp_m);
            end
            assertions++;
            if (cnt_reg_r - base_r !== exp_r) begin
                failures++;
                $display("FAIL game%0d_moves: got %0d, required %0d", g, cnt_reg_r - base_r, exp_r);
            end
        end
    endtask

    initial begin
        reset            = 1'b1;
        bus.iniciar      = 1'b0;
        bus.jogada_feita = 1'b0;
        bus.timeout      = 1'b0;
        jogada_val       = '0;
        last_round       = 0;
        for (int i = 0; i < 16; i++) rom[i] = '0;

        test_reset();
        test_round0_show();
        test_round1_play();
        test_reset_mid_show();
        test_win();
        test_wrong_move();
        test_timeout();
        test_timeout_and_move();
        test_random_games();

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
